// File: rtl/lsu_apb_master.sv
// Load/store unit front end that turns one byte/half/word request into a single APB transfer.
// Loads are extended to DATA_WIDTH here; the slave sees the raw, unshifted address and data.
module lsu_apb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  output logic                  psel,
  output logic                  penable,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  perr
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [3:0]            pstb_q, pstb_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [3:0]            req_strb;
  logic [DATA_WIDTH-1:0] load_ext;
  logic                  timeout;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    case (req_size)
      2'b00:   req_strb = 4'b0001;
      2'b01:   req_strb = 4'b0011;
      default: req_strb = 4'b1111;
    endcase
  end

  // Extension uses the size/signedness captured at accept, not the live request inputs.
  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{(DATA_WIDTH-8){prdata[7] & ~uns_q}}, prdata[7:0]};
      2'b01:   load_ext = {{(DATA_WIDTH-16){prdata[15] & ~uns_q}}, prdata[15:0]};
      default: load_ext = prdata;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pdata_q  <= '0;
      pwrite_q <= 1'b0;
      pstb_q   <= 4'b0000;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pdata_q  <= pdata_d;
      pwrite_q <= pwrite_d;
      pstb_q   <= pstb_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pdata_d  = pdata_q;
    pwrite_d = pwrite_q;
    pstb_d   = pstb_q;
    size_d   = size_q;
    uns_d    = uns_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (req_size == 2'b11) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d    = 1'b0;
            paddr_d  = req_addr;
            pdata_d  = req_wdata;
            pwrite_d = req_we;
            pstb_d   = req_we ? req_strb : 4'b0000;
            size_d   = req_size;
            uns_d    = req_unsigned;
            state_d  = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // A pready on the final allowed cycle still completes normally.
        if (pready) begin
          err_d   = perr;
          state_d = S_RESP;
          if (!pwrite_q) rdata_d = load_ext;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
    penable = (state_q == S_ACCESS);
    busy    = (state_q == S_SETUP) || (state_q == S_ACCESS);
    done    = (state_q == S_RESP);
  end

  assign paddr  = paddr_q;
  assign pdata  = pdata_q;
  assign pwrite = pwrite_q;
  assign pstb   = pstb_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

endmodule
